fifo_playback_sequencer: RTL
============================

// Module: fifo_playback_sequencer
// PURPOSE
//  Sequences the record/playback FIFO: it turns debounced save/play/abort button levels into single-cycle FIFO write, read and clear strobes.
//  Owns the per-item display dwell counter, so no external timer is needed.
//  Adds pause/resume, overflow flagging and a played-item count.
//  Sits between the button synchronisers and the FIFO / 7-seg display register.
// PARAMETERS
//  DWELL_CYCLES  50_000_000  clk cycles each item stays in SHOW (1 s at 50 MHz); must be >= 2
//  DWELL_W       26          width of the dwell counter; 2**DWELL_W > DWELL_CYCLES
//  COUNT_W       4           width of fifo_count and played_count (FIFO depth 8 -> 4)
//  AUTO_PLAY     1           1: a full FIFO in ARMED starts playback without a play press
// PORTS
//  clk           in   1        system clock
//  reset_n       in   1        asynchronous active-low reset
//  save          in   1        debounced save button, level
//  play          in   1        debounced play/pause button, level
//  abort         in   1        debounced abort button, level
//  fifo_empty    in   1        FIFO empty flag
//  fifo_full     in   1        FIFO full flag
//  fifo_wr_en    out  1        FIFO write strobe, 1 cycle
//  fifo_rd_en    out  1        FIFO read strobe, 1 cycle
//  fifo_clr      out  1        FIFO synchronous clear
//  disp_load     out  1        display register captures FIFO rd data (cycle after fifo_rd_en)
//  overflow      out  1        sticky: save was pressed while the FIFO was full
//  played_count  out  COUNT_W  items shown since playback start
//  lights        out  3        status LEDs
// BEHAVIOUR
//  Reset: async on reset_n=0.
//   - state=IDLE; edge regs=0; dwell=0; played_count=0; overflow=0.
//   - Outputs during reset: fifo_clr=1, lights=3'b001, all other outputs 0.
//  Edge detect: x_edge = x & ~x_q, with x_q a register; a held button acts once.
//  All outputs are registered-state Moore outputs, except edge-qualified transitions.
//  States:
//   IDLE: fifo_clr=1, lights=001, overflow cleared. save_edge -> WRITE.
//   WRITE: fifo_wr_en=1, lights=111. -> ARMED (abort -> IDLE).
//   ARMED: lights=010. Priority abort > save > play > auto:
//    - abort_edge -> IDLE.
//    - save_edge & !fifo_full -> WRITE.
//    - save_edge & fifo_full -> overflow<=1, stay in ARMED.
//    - play_edge & !fifo_empty -> READ, played_count<=0.
//    - play_edge & fifo_empty -> ignored.
//    - AUTO_PLAY & fifo_full -> READ, played_count<=0.
//   READ: fifo_rd_en=1, lights=111, dwell<=0. -> SHOW; abort_edge -> IDLE.
//   SHOW: lights=100. disp_load=1 only in the first SHOW cycle; played_count++ (wraps) that cycle.
//    - dwell increments each cycle.
//    - At dwell==DWELL_CYCLES-1: fifo_empty -> IDLE, else -> READ.
//    - play_edge -> PAUSE; dwell is held.
//    - abort_edge -> IDLE.
//    - Simultaneous abort + expiry: abort wins.
//    - Simultaneous play + expiry: expiry wins; play is discarded.
//   PAUSE: lights=110, dwell frozen. play_edge -> SHOW (dwell resumes); abort_edge -> IDLE.
//  Illegal state encodings -> IDLE.
//  Timing: button rise at cycle n -> edge at n -> state change at n+1 edge.
//   - Save: fifo_wr_en is high in cycle n+1.
//   - Play: fifo_rd_en in n+1, disp_load in n+2.
//  Item dwell = 1 READ cycle + DWELL_CYCLES SHOW cycles, excluding paused time.
//  Reset mid-playback: immediate IDLE, FIFO cleared, no further strobes.
//  Strobe exclusivity: fifo_wr_en and fifo_rd_en are never high together.
//   fifo_clr is never high together with either strobe.
// TESTING (bench DWELL_CYCLES=4, COUNT_W=4, AUTO_PLAY=1, FIFO model depth 8)
//  1 Reset, then save pulse:
//    - fifo_clr=1 and lights=001 while reset_n=0.
//    - Exactly one fifo_wr_en, 1 cycle after the edge; lights 111 -> 010.
//  2 Save held high 20 cycles -> only one write; release and press again -> second write.
//  3 Three saves, then play:
//    - rd/disp_load pairs spaced 5 cycles apart; played_count 1, 2, 3.
//    - fifo_empty at the third expiry -> IDLE, fifo_clr=1.
//  4 Eight saves -> full -> auto READ with no play press.
//    - A ninth save while full (held in ARMED with AUTO_PLAY=0) -> overflow=1, no wr_en.
//    - overflow clears in IDLE.
//  5 Play press 2 cycles into SHOW:
//    - lights=110; dwell frozen for 10 cycles.
//    - Play again -> remaining 2 dwell cycles, then READ.
//  6 Abort (or reset_n=0) during SHOW with 4 items left -> next cycle IDLE, fifo_clr=1, no rd_en.

Source files
------------

// File: rtl/fifo_playback_sequencer.sv
// Record/playback sequencer: turns save/play/abort button levels into single-cycle FIFO
// strobes, paces playback with an internal dwell counter and supports pause and overflow flagging.
module fifo_playback_sequencer #(
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned DWELL_W      = 26,
    parameter int unsigned COUNT_W      = 4,
    parameter bit          AUTO_PLAY    = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               save,
    input  logic               play,
    input  logic               abort,
    input  logic               fifo_empty,
    input  logic               fifo_full,
    output logic               fifo_wr_en,
    output logic               fifo_rd_en,
    output logic               fifo_clr,
    output logic               disp_load,
    output logic               overflow,
    output logic [COUNT_W-1:0] played_count,
    output logic [2:0]         lights
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWrite = 3'd1,
        StArmed = 3'd2,
        StRead  = 3'd3,
        StShow  = 3'd4,
        StPause = 3'd5
    } state_e;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    state_e               state_q, state_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [COUNT_W-1:0]   played_q, played_d;
    logic                 ovf_q, ovf_d;
    logic                 first_q, first_d;
    logic                 save_q, play_q, abort_q;
    logic                 save_edge, play_edge, abort_edge;
    logic                 dwell_done;

    assign save_edge  = save & ~save_q;
    assign play_edge  = play & ~play_q;
    assign abort_edge = abort & ~abort_q;
    assign dwell_done = (dwell_q == DWELL_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            dwell_q  <= '0;
            played_q <= '0;
            ovf_q    <= 1'b0;
            first_q  <= 1'b0;
            save_q   <= 1'b0;
            play_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            played_q <= played_d;
            ovf_q    <= ovf_d;
            first_q  <= first_d;
            save_q   <= save;
            play_q   <= play;
            abort_q  <= abort;
        end
    end

    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        played_d = played_q;
        ovf_d    = ovf_q;
        first_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                ovf_d = 1'b0;
                if (save_edge) state_d = StWrite;
            end
            StWrite: begin
                state_d = abort_edge ? StIdle : StArmed;
            end
            StArmed: begin
                if (abort_edge) begin
                    state_d = StIdle;
                end else if (save_edge) begin
                    if (fifo_full) ovf_d = 1'b1;
                    else           state_d = StWrite;
                end else if (play_edge && !fifo_empty) begin
                    state_d  = StRead;
                    played_d = '0;
                end else if (AUTO_PLAY && fifo_full) begin
                    state_d  = StRead;
                    played_d = '0;
                end
            end
            StRead: begin
                dwell_d = '0;
                if (abort_edge) begin
                    state_d = StIdle;
                end else begin
                    state_d = StShow;
                    first_d = 1'b1;
                end
            end
            StShow: begin
                dwell_d = dwell_q + DWELL_W'(1);
                if (first_q) played_d = played_q + COUNT_W'(1);
                // Abort beats expiry, and expiry swallows a coincident play press.
                if (abort_edge)      state_d = StIdle;
                else if (dwell_done) state_d = fifo_empty ? StIdle : StRead;
                else if (play_edge)  state_d = StPause;
            end
            StPause: begin
                if (abort_edge)     state_d = StIdle;
                else if (play_edge) state_d = StShow;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        fifo_wr_en = 1'b0;
        fifo_rd_en = 1'b0;
        fifo_clr   = 1'b0;
        disp_load  = 1'b0;
        lights     = 3'b000;
        unique case (state_q)
            StIdle: begin
                fifo_clr = 1'b1;
                lights   = 3'b001;
            end
            StWrite: begin
                fifo_wr_en = 1'b1;
                lights     = 3'b111;
            end
            StArmed: lights = 3'b010;
            StRead: begin
                fifo_rd_en = 1'b1;
                lights     = 3'b111;
            end
            StShow: begin
                disp_load = first_q;
                lights    = 3'b100;
            end
            StPause: lights = 3'b110;
            default: lights = 3'b000;
        endcase
    end

    assign overflow     = ovf_q;
    assign played_count = played_q;

endmodule
